// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared system bus.
// Grants one master at a time with a one-cycle grant pulse, follows the
// granted transaction from begin to end, and recovers the bus from masters
// that never start (begin timeout) or that hang it (watchdog abort).
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   requests            per-master request levels
//   beginTransactionIn  OR of the masters' beginTransaction
//   endTransactionIn    bus endTransaction
//   busErrorIn          bus error from the slave (no effect on sequencing)
//   grants              one-hot grant pulse, one cycle, registered
//   activeMaster        index of the current or last granted master
//   busBusy             high in GRANT, WAIT_BEGIN, BUSY and ABORT
//   endTransactionOut   arbiter-driven end, ABORT only
//   busErrorOut         arbiter-driven error, ABORT only
//   timeoutFlag         sticky: a begin timeout or watchdog abort occurred
module bus_arbiter_rr #(
  parameter int unsigned NUM_MASTERS     = 4,
  parameter int unsigned MASTER_BITS     = 2,
  parameter int unsigned BEGIN_TIMEOUT   = 8,
  parameter int unsigned WATCHDOG_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] requests,
  input  logic                   beginTransactionIn,
  input  logic                   endTransactionIn,
  input  logic                   busErrorIn,
  output logic [NUM_MASTERS-1:0] grants,
  output logic [MASTER_BITS-1:0] activeMaster,
  output logic                   busBusy,
  output logic                   endTransactionOut,
  output logic                   busErrorOut,
  output logic                   timeoutFlag
);

  localparam int unsigned BEGIN_W = 8;
  localparam int unsigned WD_W    = 16;

  localparam logic [BEGIN_W-1:0]     BEGIN_LAST  = BEGIN_W'(BEGIN_TIMEOUT - 1);
  localparam logic [WD_W-1:0]        WD_LAST     = WD_W'(WATCHDOG_CYCLES - 1);
  localparam logic                   WD_EN       = (WATCHDOG_CYCLES != 0);
  localparam logic [MASTER_BITS-1:0] LAST_MASTER = MASTER_BITS'(NUM_MASTERS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT_BEGIN,
    S_BUSY,
    S_ABORT
  } state_t;

  state_t                 state;
  logic [MASTER_BITS-1:0] ptr;
  logic [MASTER_BITS-1:0] win_idx;
  logic [BEGIN_W-1:0]     begin_cnt;
  logic [WD_W-1:0]        wd_cnt;

  // The slave error is informational here: whoever raised it owns the end.
  logic unused_inputs;
  assign unused_inputs = busErrorIn;

  // Winner search: scan downward so the last hit is the first set bit
  // at or after ptr in circular order.
  always_comb begin : win_search
    int unsigned idx;
    idx     = 0;
    win_idx = '0;
    for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (requests[MASTER_BITS'(idx)]) win_idx = MASTER_BITS'(idx);
    end
  end

  // Status outputs decode straight from the state register.
  assign busBusy           = (state != S_IDLE);
  assign endTransactionOut = (state == S_ABORT);
  assign busErrorOut       = (state == S_ABORT);

  // Arbitration and transaction-tracking state machine.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      grants       <= '0;
      activeMaster <= '0;
      ptr          <= '0;
      begin_cnt    <= '0;
      wd_cnt       <= '0;
      timeoutFlag  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (requests != '0) begin
            grants       <= NUM_MASTERS'(1) << win_idx;
            activeMaster <= win_idx;
            ptr          <= (win_idx == LAST_MASTER) ? '0 : win_idx + MASTER_BITS'(1);
            state        <= S_GRANT;
          end
        end
        S_GRANT: begin
          grants    <= '0;
          begin_cnt <= '0;
          state     <= S_WAIT_BEGIN;
        end
        S_WAIT_BEGIN: begin
          // A begin on the last allowed cycle still wins over the timeout.
          if (beginTransactionIn) begin
            wd_cnt <= '0;
            state  <= S_BUSY;
          end else if (begin_cnt == BEGIN_LAST) begin
            timeoutFlag <= 1'b1;
            state       <= S_IDLE;
          end else begin
            begin_cnt <= begin_cnt + BEGIN_W'(1);
          end
        end
        S_BUSY: begin
          // A real end in the expiry cycle beats the watchdog.
          if (endTransactionIn) begin
            state <= S_IDLE;
          end else if (WD_EN && (wd_cnt == WD_LAST)) begin
            state <= S_ABORT;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        S_ABORT: begin
          timeoutFlag <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          grants <= '0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
Round-robin arbiter for the shared system bus. Up to NUM_MASTERS bus masters share the bus: DMA custom-instruction blocks, the CPU fetch/data ports, and display/camera engines. Each master raises requestTransaction and waits for a one-cycle transactionGranted pulse. The arbiter then tracks the granted transaction through beginTransaction…endTransaction, and aborts masters that never start or that hang the bus.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16)
MASTER_BITS, 2, width of the activeMaster index; must equal ceil(log2(NUM_MASTERS))
BEGIN_TIMEOUT, 8, cycles allowed between the grant pulse and beginTransactionIn (1..255)
WATCHDOG_CYCLES, 1024, maximum cycles a transaction may stay BUSY; 0 disables the watchdog (16-bit counter)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
requests  in  NUM_MASTERS  requestTransaction from each master, level
beginTransactionIn  in  1  OR of bus beginTransaction
endTransactionIn  in  1  bus endTransaction (from the slave or the master)
busErrorIn  in  1  bus error from the slave
grants  out  NUM_MASTERS  one-hot transactionGranted pulses, registered
activeMaster  out  MASTER_BITS  index of the current or last granted master
busBusy  out  1  high in states GRANT, WAIT_BEGIN, BUSY and ABORT
endTransactionOut  out  1  arbiter-driven endTransaction, asserted in ABORT only
busErrorOut  out  1  arbiter-driven busError, asserted in ABORT only
timeoutFlag  out  1  sticky flag: a begin-timeout or watchdog abort occurred; cleared only by reset

Behaviour:
- Reset values:
  - State IDLE.
  - grants=0, activeMaster=0, busBusy=0.
  - endTransactionOut=0, busErrorOut=0, timeoutFlag=0.
  - Round-robin pointer ptr=0; counters=0.
  - Reset mid-transaction forces IDLE on the next edge; no ABORT pulse is issued.
- All outputs are registered, or decoded from the state register only.
- IDLE:
  - If requests!=0, select winner w = the first set bit scanning ptr, ptr+1, …, NUM_MASTERS-1, 0, …, ptr-1.
  - On that edge: grants<=onehot(w), activeMaster<=w, ptr<=(w+1) mod NUM_MASTERS, go to GRANT.
  - Request-to-grant latency is 1 cycle. With no requests, stay in IDLE.
- GRANT:
  - grants is high for exactly this one cycle.
  - Next state is WAIT_BEGIN; grants<=0; beginCnt<=0.
- WAIT_BEGIN:
  - beginTransactionIn=1 -> BUSY, wdCnt<=0.
  - Otherwise beginCnt++; when beginCnt==BEGIN_TIMEOUT-1 -> IDLE, timeoutFlag<=1.
  - No bus signals are driven on this timeout: the master never started.
  - A master that samples its grant starts in the cycle after GRANT.
- BUSY:
  - endTransactionIn=1 -> IDLE, with or without busErrorIn.
  - busErrorIn=1 without endTransactionIn: stay in BUSY and wait for the end; the erroring master or slave is responsible for the end.
  - wdCnt++ each cycle. When WATCHDOG_CYCLES!=0 and wdCnt==WATCHDOG_CYCLES-1 -> ABORT.
  - If endTransactionIn arrives in the same cycle as the watchdog expiry, it wins: go to IDLE, no abort.
- ABORT:
  - One cycle with endTransactionOut=1 and busErrorOut=1; timeoutFlag<=1; then IDLE.
- Back-to-back operation:
  - IDLE is visited for at least one cycle between transactions, so the minimum gap between grant pulses is 1 idle cycle plus the transaction length.
  - A master holding its request continuously is re-granted only after the other requesters are served.
- Request withdrawn while in GRANT or WAIT_BEGIN: no special handling; the begin-timeout recovers the bus.
- beginTransactionIn seen while in IDLE, GRANT or BUSY: ignored.

Test Plan:
1. Single requester: after reset, requests=4'b0100 at cycle 0 -> grants=4'b0100 only at cycle 1, activeMaster=2. Then begin at cycle 2 and endTransactionIn at cycle 10 -> busBusy falls at cycle 11 and ptr=3.
2. Round-robin fairness: requests held at 4'b1111, each master begins 1 cycle after its grant and ends 3 cycles later -> grant order 0,1,2,3,0. Repeat from ptr=3 with requests=4'b1001 -> order 3,0,3.
3. Begin timeout: grant to master 1, no beginTransactionIn -> exactly BEGIN_TIMEOUT=8 cycles in WAIT_BEGIN, then IDLE. timeoutFlag=1; endTransactionOut and busErrorOut stay 0.
4. Watchdog: WATCHDOG_CYCLES=16, begin issued and no end -> endTransactionOut=busErrorOut=1 for exactly one cycle, 16 cycles after BUSY entry, then IDLE. A second run with end at the 16th BUSY cycle -> no abort.
5. Bus error: busErrorIn pulsed mid-BUSY without end -> stays BUSY; later endTransactionIn -> IDLE, timeoutFlag stays 0.
6. Reset mid-BUSY with requests=4'b0011 -> next cycle in IDLE with all outputs 0 and ptr=0. The grant then goes to master 0 one cycle after reset deasserts.
